riscv_cpu: RTL and testbench
============================

RISCV_CPU -- requirements
Module: riscv_cpu

Interface
REQ-001 Parameter IMEM_WORDS, default 1024: instruction memory depth in 32-bit words.
REQ-002 Parameter DMEM_WORDS, default 1024: data memory depth in 32-bit words.
REQ-003 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 Internal arrays SHALL be named IMemory[0:IMEM_WORDS-1] (32b), DMemory[0:DMEM_WORDS-1] (32b) and Regs[0:31] (32b), hierarchically accessible for bench preload and readout.
REQ-006 No other ports; program and data are supplied through hierarchical preload.

Function
REQ-007 Classic 5-stage in-order pipeline: IF, ID, EX, MEM, WB, with pipeline registers IF/ID, ID/EX, EX/MEM, MEM/WB.
REQ-008 IF: fetch IMemory[PC[11:2]]; PC += 4 each cycle unless stalled or redirected.
REQ-009 Opcode 7'b0010011 SHALL be an R-format ALU op: rd = Regs[rs1] op Regs[rs2], using instruction fields [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:7]=rd, [31:25]=funct7.
REQ-010 ALU ops for 0010011: funct3 000 with funct7 0000000 = add; funct3 000 with funct7 0100000 = sub; 111 = and; 110 = or; 100 = xor; 010 = slt (signed); any other combination = add.
REQ-011 Opcode 0000011 (lw): rd = DMemory[(rs1 + sext(imm[31:20]))[11:2]].
REQ-012 Opcode 0100011 (sw): DMemory[(rs1 + sext({[31:25],[11:7]}))[11:2]] = rs2, written in MEM.
REQ-013 Opcode 1100011 (beq): if rs1 == rs2, PC = branch PC + sext(B-immediate); resolved in EX.
REQ-014 Any other opcode SHALL execute as a NOP: no register write, no memory write.
REQ-015 32'h00000013 SHALL behave as a NOP; it decodes as add x0,x0,x0, and writes to x0 are discarded.
REQ-016 Register x0 reads SHALL always return 0; writes to rd=0 SHALL be suppressed.
REQ-017 Register file written in WB on the rising edge; an ID-stage read of the register being written in the same cycle SHALL return the new value (write-through).
REQ-018 Forwarding into EX operands: EX/MEM result has priority over MEM/WB result; forward only when the source rd is non-zero and the source instruction writes a register.
REQ-019 Load-use hazard: if the ID/EX instruction is lw and its rd (non-zero) matches the rs1/rs2 used by the instruction in ID, hold PC and IF/ID for one cycle and insert a NOP into ID/EX.
REQ-020 Taken beq: flush IF/ID and ID/EX to NOP, redirect PC; 2-cycle penalty. Not-taken: no penalty (predict not-taken).
REQ-021 Arithmetic is 32-bit two's complement; overflow wraps silently.
REQ-022 Latency: an instruction fetched in cycle N writes back at the end of cycle N+4; throughput is one instruction per cycle absent hazards.
REQ-023 Memory addresses wrap modulo depth (index bits only; no alignment trap).

Reset
REQ-024 While reset_n=0: PC=0; all pipeline registers hold the NOP 32'h00000013 with all control signals deasserted.
REQ-025 Reset SHALL NOT clear Regs, IMemory or DMemory, so preloaded contents survive reset.
REQ-026 Reset asserted mid-operation SHALL squash all in-flight instructions (no later register or memory writes); fetch restarts at address 0 on the first rising edge after release.

Verification
REQ-027 Preload Regs[i]=i; program add x1,x10,x11; add x2,x12,x13; add x3,x1,x2; add x4,x3,x1; rest NOP; run 20 cycles -> x1=21, x2=25, x3=46, x4=67, x0=0, all other Regs[i]=i.
REQ-028 sw x5,0(x0) then lw x6,0(x0) then add x7,x6,x6 with Regs[5]=5 -> DMemory[0]=5, x6=5, x7=10; exactly one stall cycle inserted.
REQ-029 beq x1,x1,+8 followed by add x9,x10,x11, then target add x8,x10,x10 -> x9 unchanged (9), x8=20.
REQ-030 add x0,x10,x11 followed by add x12,x0,x0 -> x0=0, x12=0.
REQ-031 Assert reset_n=0 for 1 cycle while a 4-instruction add chain is in flight -> uncompleted instructions do not write; the program re-executes from PC=0 after release.
REQ-032 beq x1,x2 with x1!=x2 -> falls through with no bubble; the sequential instruction's result is written.

Source files
------------

// File: rtl/riscv_cpu.sv
// Five-stage in-order RV32 subset core (ALU R-ops on opcode 0010011, lw, sw, beq) with
// EX forwarding, load-use stall and predict-not-taken branches resolved in EX.
module riscv_cpu #(
  parameter int unsigned IMEM_WORDS = 1024,
  parameter int unsigned DMEM_WORDS = 1024
) (
  input logic clock,
  input logic reset_n
);

  localparam int unsigned IAW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam int unsigned DAW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

  localparam logic [31:0] NopInstr = 32'h0000_0013;
  localparam logic [6:0]  OpAlu    = 7'b0010011;
  localparam logic [6:0]  OpLoad   = 7'b0000011;
  localparam logic [6:0]  OpStore  = 7'b0100011;
  localparam logic [6:0]  OpBranch = 7'b1100011;

  logic [31:0] IMemory [0:IMEM_WORDS-1];
  logic [31:0] DMemory [0:DMEM_WORDS-1];
  logic [31:0] Regs    [0:31];

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        sub;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        reg_write;
  } mem_wb_t;

  localparam if_id_t IfIdNop = '{instr: NopInstr, pc: 32'h0};

  logic [31:0] pc_q, pc_d;
  if_id_t      if_id_q, if_id_d;
  id_ex_t      id_ex_q, id_ex_d;
  ex_mem_t     ex_mem_q, ex_mem_d;
  mem_wb_t     mem_wb_q, mem_wb_d;

  // ---------------------------------------------------------------- IF
  logic [31:0] if_instr;
  assign if_instr = IMemory[pc_q[IAW+1:2]];

  // ---------------------------------------------------------------- ID
  logic [31:0] id_instr;
  logic [6:0]  id_opcode;
  logic [6:0]  id_funct7;
  logic [2:0]  id_funct3;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_is_alu, id_is_load, id_is_store, id_is_branch;
  logic        id_uses_rs1, id_uses_rs2;
  logic [31:0] id_imm;
  logic [31:0] id_rs1_val, id_rs2_val;
  logic        load_use;

  assign id_instr     = if_id_q.instr;
  assign id_opcode    = id_instr[6:0];
  assign id_rd        = id_instr[11:7];
  assign id_funct3    = id_instr[14:12];
  assign id_rs1       = id_instr[19:15];
  assign id_rs2       = id_instr[24:20];
  assign id_funct7    = id_instr[31:25];
  assign id_is_alu    = (id_opcode == OpAlu);
  assign id_is_load   = (id_opcode == OpLoad);
  assign id_is_store  = (id_opcode == OpStore);
  assign id_is_branch = (id_opcode == OpBranch);
  assign id_uses_rs1  = id_is_alu | id_is_load | id_is_store | id_is_branch;
  assign id_uses_rs2  = id_is_alu | id_is_store | id_is_branch;

  always_comb begin
    case (id_opcode)
      OpStore:  id_imm = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
      OpBranch: id_imm = {{19{id_instr[31]}}, id_instr[31], id_instr[7], id_instr[30:25],
                          id_instr[11:8], 1'b0};
      default:  id_imm = {{20{id_instr[31]}}, id_instr[31:20]};
    endcase
  end

  // Write-through: a WB write in this cycle is visible to the ID read.
  always_comb begin
    id_rs1_val = 32'h0;
    id_rs2_val = 32'h0;
    if (id_rs1 != 5'd0) begin
      if (mem_wb_q.reg_write && (mem_wb_q.rd == id_rs1)) id_rs1_val = mem_wb_q.result;
      else                                                id_rs1_val = Regs[id_rs1];
    end
    if (id_rs2 != 5'd0) begin
      if (mem_wb_q.reg_write && (mem_wb_q.rd == id_rs2)) id_rs2_val = mem_wb_q.result;
      else                                                id_rs2_val = Regs[id_rs2];
    end
  end

  assign load_use = id_ex_q.mem_read && (id_ex_q.rd != 5'd0) &&
                    ((id_uses_rs1 && (id_ex_q.rd == id_rs1)) ||
                     (id_uses_rs2 && (id_ex_q.rd == id_rs2)));

  // ---------------------------------------------------------------- EX
  logic [31:0] ex_a, ex_b, ex_alu, ex_result, ex_target;
  logic        ex_taken;

  // A load still in EX/MEM has no data yet; the load-use stall keeps that case from arising.
  always_comb begin
    if (ex_mem_q.reg_write && !ex_mem_q.mem_read && (ex_mem_q.rd == id_ex_q.rs1)) begin
      ex_a = ex_mem_q.result;
    end else if (mem_wb_q.reg_write && (mem_wb_q.rd == id_ex_q.rs1)) begin
      ex_a = mem_wb_q.result;
    end else begin
      ex_a = id_ex_q.rs1_val;
    end
    if (ex_mem_q.reg_write && !ex_mem_q.mem_read && (ex_mem_q.rd == id_ex_q.rs2)) begin
      ex_b = ex_mem_q.result;
    end else if (mem_wb_q.reg_write && (mem_wb_q.rd == id_ex_q.rs2)) begin
      ex_b = mem_wb_q.result;
    end else begin
      ex_b = id_ex_q.rs2_val;
    end
  end

  always_comb begin
    case (id_ex_q.funct3)
      3'b111:  ex_alu = ex_a & ex_b;
      3'b110:  ex_alu = ex_a | ex_b;
      3'b100:  ex_alu = ex_a ^ ex_b;
      3'b010:  ex_alu = {31'h0, ($signed(ex_a) < $signed(ex_b))};
      default: ex_alu = id_ex_q.sub ? (ex_a - ex_b) : (ex_a + ex_b);
    endcase
  end

  assign ex_result = (id_ex_q.mem_read || id_ex_q.mem_write) ? (ex_a + id_ex_q.imm) : ex_alu;
  assign ex_taken  = id_ex_q.branch && (ex_a == ex_b);
  assign ex_target = id_ex_q.pc + id_ex_q.imm;

  // ---------------------------------------------------------------- MEM
  logic [DAW-1:0] mem_idx;
  logic [31:0]    mem_rdata;

  assign mem_idx   = ex_mem_q.result[DAW+1:2];
  assign mem_rdata = DMemory[mem_idx];

  always_ff @(posedge clock) begin
    if (ex_mem_q.mem_write) DMemory[mem_idx] <= ex_mem_q.store_data;
  end

  // ---------------------------------------------------------------- WB
  always_ff @(posedge clock) begin
    if (mem_wb_q.reg_write) Regs[mem_wb_q.rd] <= mem_wb_q.result;
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    pc_d     = pc_q + 32'd4;
    if_id_d  = '{instr: if_instr, pc: pc_q};
    id_ex_d  = '{pc:        if_id_q.pc,
                 rs1_val:   id_rs1_val,
                 rs2_val:   id_rs2_val,
                 imm:       id_imm,
                 rs1:       id_rs1,
                 rs2:       id_rs2,
                 rd:        id_rd,
                 funct3:    id_funct3,
                 sub:       (id_funct3 == 3'b000) && (id_funct7 == 7'b0100000),
                 reg_write: (id_is_alu || id_is_load) && (id_rd != 5'd0),
                 mem_read:  id_is_load,
                 mem_write: id_is_store,
                 branch:    id_is_branch};
    ex_mem_d = '{result:     ex_result,
                 store_data: ex_b,
                 rd:         id_ex_q.rd,
                 reg_write:  id_ex_q.reg_write,
                 mem_read:   id_ex_q.mem_read,
                 mem_write:  id_ex_q.mem_write};
    mem_wb_d = '{result:    ex_mem_q.mem_read ? mem_rdata : ex_mem_q.result,
                 rd:        ex_mem_q.rd,
                 reg_write: ex_mem_q.reg_write};
    if (ex_taken) begin
      pc_d    = ex_target;
      if_id_d = IfIdNop;
      id_ex_d = '0;
    end else if (load_use) begin
      pc_d    = pc_q;
      if_id_d = if_id_q;
      id_ex_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q     <= 32'h0;
      if_id_q  <= IfIdNop;
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      pc_q     <= pc_d;
      if_id_q  <= if_id_d;
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

endmodule

// File: tb/tb_riscv_cpu.sv
// Directed and random-program bench for riscv_cpu; results are compared against a sequential
// instruction-set interpreter that ignores pipelining entirely.
module tb_riscv_cpu;

  localparam int unsigned IW = 1024;
  localparam int unsigned DW = 1024;
  localparam logic [31:0] Nop = 32'h0000_0013;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  riscv_cpu #(.IMEM_WORDS(IW), .DMEM_WORDS(DW)) dut (.clock(clock), .reset_n(reset_n));

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [31:0] prog   [$];
  logic [31:0] m_regs [32];
  logic [31:0] m_dmem [DW];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int f7, input int f3, input int rd, input int rs1,
                                        input int rs2);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_add(input int rd, input int rs1, input int rs2);
    return enc_r(0, 0, rd, rs1, rs2);
  endfunction

  function automatic logic [31:0] enc_lw(input int rd, input int rs1, input int imm);
    return {12'(imm), 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
  endfunction

  function automatic logic [31:0] enc_sw(input int rs2, input int rs1, input int imm);
    logic [11:0] i;
    i = 12'(imm);
    return {i[11:5], 5'(rs2), 5'(rs1), 3'b010, i[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_beq(input int rs1, input int rs2, input int off);
    logic [12:0] o;
    o = 13'(off);
    return {o[12], o[10:5], 5'(rs2), 5'(rs1), 3'b000, o[4:1], o[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] ref_alu(input int f3, input int f7, input logic [31:0] a,
                                          input logic [31:0] b);
    if (f3 == 0 && f7 == 32) return a - b;
    case (f3)
      7:       return a & b;
      6:       return a | b;
      4:       return a ^ b;
      2:       return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return a + b;
    endcase
  endfunction

  // Architectural interpreter: one instruction at a time, PC in word units.
  task automatic ref_run();
    int pc;
    int steps;
    pc = 0;
    steps = 0;
    while (pc >= 0 && pc < prog.size() && steps < 4096) begin
      logic [31:0] ins, a, b, addr;
      int op, rd, rs1, rs2, f3, f7, next;
      ins = prog[pc];
      op  = int'(ins[6:0]);
      rd  = int'(ins[11:7]);
      f3  = int'(ins[14:12]);
      rs1 = int'(ins[19:15]);
      rs2 = int'(ins[24:20]);
      f7  = int'(ins[31:25]);
      a = m_regs[rs1];
      b = m_regs[rs2];
      next = pc + 1;
      if (op == 'h13) begin
        if (rd != 0) m_regs[rd] = ref_alu(f3, f7, a, b);
      end else if (op == 'h03) begin
        addr = a + 32'($signed(ins[31:20]));
        if (rd != 0) m_regs[rd] = m_dmem[(addr / 4) % DW];
      end else if (op == 'h23) begin
        addr = a + 32'($signed({ins[31:25], ins[11:7]}));
        m_dmem[(addr / 4) % DW] = b;
      end else if (op == 'h63) begin
        if (a == b) next = pc + int'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0})) / 4;
      end
      pc = next;
      steps++;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic identity_state();
    prog.delete();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'(i);
    for (int i = 0; i < DW; i++) m_dmem[i] = 32'h0;
  endtask

  // Preload under reset, release on a falling edge; the next rising edge fetches word 0.
  task automatic start_program();
    @(negedge clock);
    reset_n = 1'b0;
    for (int i = 0; i < IW; i++) dut.IMemory[i] <= (i < prog.size()) ? prog[i] : Nop;
    for (int i = 0; i < 32; i++) dut.Regs[i] <= m_regs[i];
    for (int i = 0; i < DW; i++) dut.DMemory[i] <= m_dmem[i];
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic compare_all(input string tag);
    for (int r = 0; r < 32; r++) check($sformatf("%s x%0d", tag, r), dut.Regs[r], m_regs[r]);
    for (int d = 0; d < DW; d++) check($sformatf("%s dmem[%0d]", tag, d), dut.DMemory[d],
                                       m_dmem[d]);
  endtask

  initial begin
    // Reset state
    #1 reset_n = 1'b0;
    #1;
    check("reset pc", dut.pc_q, 32'h0);
    check("reset if_id instr", dut.if_id_q.instr, Nop);
    check("reset ctrl", 32'({dut.id_ex_q.reg_write, dut.id_ex_q.mem_read, dut.id_ex_q.mem_write,
                            dut.id_ex_q.branch, dut.ex_mem_q.reg_write, dut.ex_mem_q.mem_read,
                            dut.ex_mem_q.mem_write, dut.mem_wb_q.reg_write}), 32'h0);
    cyc(2);
    check("reset pc held", dut.pc_q, 32'h0);

    // Forwarding chain
    identity_state();
    prog = '{enc_add(1, 10, 11), enc_add(2, 12, 13), enc_add(3, 1, 2), enc_add(4, 3, 1)};
    start_program();
    ref_run();
    cyc(4);
    check("latency x1 early", dut.Regs[1], 32'd1);
    cyc(1);
    check("latency x1 N+4", dut.Regs[1], 32'd21);
    cyc(15);
    check("chain x3", dut.Regs[3], 32'd46);
    check("chain x4", dut.Regs[4], 32'd67);
    compare_all("chain");

    // Store, load, dependent use: exactly one bubble
    identity_state();
    prog = '{enc_sw(5, 0, 0), enc_lw(6, 0, 0), enc_add(7, 6, 6)};
    start_program();
    ref_run();
    cyc(7);
    check("load-use x7 before", dut.Regs[7], 32'd7);
    cyc(1);
    check("load-use x7 one stall", dut.Regs[7], 32'd10);
    cyc(12);
    check("load-use dmem0", dut.DMemory[0], 32'd5);
    check("load-use x6", dut.Regs[6], 32'd5);
    compare_all("loaduse");

    // Taken branch skips the shadow instruction
    identity_state();
    prog = '{enc_beq(1, 1, 8), enc_add(9, 10, 11), enc_add(8, 10, 10)};
    start_program();
    ref_run();
    cyc(7);
    check("taken x8 before", dut.Regs[8], 32'd8);
    cyc(1);
    check("taken x8 penalty 2", dut.Regs[8], 32'd20);
    cyc(10);
    check("taken x9 squashed", dut.Regs[9], 32'd9);
    compare_all("taken");

    // x0 writes discarded and never forwarded
    identity_state();
    prog = '{enc_add(0, 10, 11), enc_add(12, 0, 0)};
    start_program();
    ref_run();
    cyc(12);
    check("x0 stays zero", dut.Regs[0], 32'd0);
    check("x12 from x0", dut.Regs[12], 32'd0);
    compare_all("x0");

    // Not-taken branch: no bubble
    identity_state();
    prog = '{enc_beq(1, 2, 8), enc_add(9, 10, 11), enc_add(8, 10, 10)};
    start_program();
    ref_run();
    cyc(5);
    check("nottaken x9 before", dut.Regs[9], 32'd9);
    cyc(1);
    check("nottaken x9 no bubble", dut.Regs[9], 32'd21);
    cyc(10);
    compare_all("nottaken");

    // Reset mid-flight squashes and restarts from 0
    identity_state();
    prog = '{enc_add(1, 10, 11), enc_add(2, 1, 1), enc_add(3, 2, 1), enc_add(4, 3, 2)};
    start_program();
    ref_run();
    cyc(5);
    check("midrst x1 done", dut.Regs[1], 32'd21);
    check("midrst x2 pending", dut.Regs[2], 32'd2);
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    check("midrst x2 squashed", dut.Regs[2], 32'd2);
    check("midrst x3 squashed", dut.Regs[3], 32'd3);
    check("midrst x4 squashed", dut.Regs[4], 32'd4);
    cyc(5);
    check("midrst x2 not yet", dut.Regs[2], 32'd2);
    cyc(1);
    check("midrst x2 rerun", dut.Regs[2], 32'd42);
    cyc(10);
    compare_all("midrst");

    // Random programs against the interpreter
    for (int t = 0; t < 8; t++) begin
      prog.delete();
      m_regs[0] = 32'h0;
      for (int r = 1; r < 32; r++) m_regs[r] = (r < 4) ? 32'($urandom_range(0, 63) * 4) : $urandom;
      for (int d = 0; d < DW; d++) m_dmem[d] = $urandom;
      for (int k = 0; k < 24; k++) begin
        int sel, rd, rs1, rs2, imm;
        logic [31:0] w;
        sel = int'($urandom_range(0, 9));
        rd  = int'($urandom_range(0, 7));
        rs1 = int'($urandom_range(0, 7));
        rs2 = int'($urandom_range(0, 7));
        imm = (int'($urandom_range(0, 3)) - 1) * 4;
        if (sel <= 4) begin
          w = enc_r(($urandom_range(0, 2) == 0) ? 32 : (($urandom_range(0, 3) == 0)
                    ? int'($urandom_range(0, 127)) : 0), int'($urandom_range(0, 7)), rd, rs1, rs2);
        end else if (sel == 5) begin
          w = enc_lw(rd, rs1, imm);
        end else if (sel == 6) begin
          w = enc_sw(rs2, rs1, imm);
        end else if (sel == 7) begin
          w = enc_beq(rs1, ($urandom_range(0, 1) == 0) ? rs1 : rs2,
                      int'($urandom_range(1, 4)) * 4);
        end else if (sel == 8) begin
          w = $urandom;
          case ($urandom_range(0, 2))
            0:       w[6:0] = 7'b0110011;
            1:       w[6:0] = 7'b1101111;
            default: w[6:0] = 7'b0000000;
          endcase
        end else begin
          w = Nop;
        end
        prog.push_back(w);
      end
      start_program();
      ref_run();
      cyc(3 * 24 + 10);
      compare_all($sformatf("rand%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
